exception_ctrl: RTL and testbench
=================================

# exception_ctrl

Multicycle exception sequencer sitting directly upstream of the memory-address mux. On an invalid-opcode, overflow or divide-by-zero event it saves the faulting PC into EPC and drives the mux select to the matching exception vector address (253/254/255). It then waits out the memory read latency and loads the PC with the handler address byte read from memory. While idle it drives select 3'b000 (PC), so normal fetch proceeds.

## Interface
Parameters:
- MEM_WAIT, 2, cycles between address presentation and valid memData (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; all state and outputs to reset values
- opcodeErr  input  1  invalid-opcode event, sampled only in IDLE
- overflowErr  input  1  ALU overflow event, sampled only in IDLE
- divZeroErr  input  1  divide-by-zero event, sampled only in IDLE
- pcOut  input  32  current PC (already incremented past the faulting instruction)
- memData  input  32  memory read data
- iordmux  output  3  memory address select: 000 PC, 011 opcode vector, 100 overflow vector, 101 div-zero vector
- epcOut  output  32  EPC value
- epcWrite  output  1  one-cycle EPC load strobe
- pcIn  output  32  new PC value
- pcLoad  output  1  one-cycle PC load strobe
- busy  output  1  high while the sequence runs; the control unit stalls on it
- cause  output  2  last cause: 00 none, 01 opcode, 10 overflow, 11 div-zero

## Operation
- States: IDLE, SAVE, WAIT, LOAD.
- IDLE: iordmux=000, busy=0, strobes 0. On a rising edge with any event high:
  - latch cause.
  - latch epcOut = pcOut - 32'd4, modulo 2^32.
  - load the wait counter with MEM_WAIT.
  - go to SAVE.
- Simultaneous events: priority opcodeErr > overflowErr > divZeroErr. Lower-priority events are dropped.
- SAVE (1 cycle):
  - epcWrite=1.
  - iordmux = vector code for the latched cause.
  - go to WAIT.
- WAIT (MEM_WAIT cycles):
  - iordmux held at the vector code.
  - counter decrements each cycle; leave for LOAD when it reaches 1.
- LOAD (1 cycle):
  - pcLoad=1, iordmux held.
  - pcIn = {24'd0, memData[7:0]}, combinational from memData.
  - go to IDLE.
- busy = (state != IDLE).
- Events arriving in SAVE, WAIT or LOAD are ignored. No queueing.
- cause and epcOut keep their value until the next exception.
- pcIn reads 0 outside LOAD.
- Reset mid-sequence: immediate return to IDLE. No partial PC load occurs after reset deasserts.

## Timing
- Reset values:
  - state IDLE, iordmux 000, epcOut 0, epcWrite 0, pcIn 0, pcLoad 0, busy 0, cause 00.
- Event at edge k. SAVE covers cycle k..k+1 (epcWrite high). WAIT covers the next MEM_WAIT cycles. LOAD covers the following cycle. IDLE resumes at edge k+2+MEM_WAIT.
- busy is high for exactly MEM_WAIT+2 cycles. The vector select is held for the same span.
- Strobes are registered-state decodes with no combinational input-to-strobe path. pcIn is the only combinational output (from memData).

## Configuration
- EXC_DIVZERO_EN defined:
  - divZeroErr is recognised.
  - code 101 and cause 11 are produced.
- EXC_DIVZERO_EN undefined:
  - divZeroErr is ignored. It alone never leaves IDLE.
  - iordmux never shows 101 and cause never shows 11.
  - all other behaviour is identical.

## Test plan
- Reset then idle 5 cycles -> all outputs at reset values, iordmux=000, busy=0.
- MEM_WAIT=2, pcOut=32'h0000_0040, overflowErr pulse:
  - epcWrite high 1 cycle, epcOut=32'h0000_003C.
  - iordmux=100 for 4 cycles.
  - memData=32'hFFFF_FF2A in LOAD -> pcIn=32'h0000_002A, pcLoad high 1 cycle, cause=10.
- opcodeErr, overflowErr and divZeroErr high on the same edge -> iordmux=011, cause=01. No second sequence follows.
- pcOut=0 with divZeroErr -> epcOut=32'hFFFF_FFFC, iordmux=101 (macro defined). With the macro undefined: busy stays 0, iordmux stays 000.
- overflowErr raised during WAIT of an opcode sequence -> ignored; after LOAD, busy=0 and cause=01.
- reset asserted in the middle of WAIT -> outputs immediately at reset values; after release, no pcLoad pulse.

Source files
------------

// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
//
// Multicycle exception sequencer placed directly upstream of the memory
// address mux. When an invalid-opcode, overflow or divide-by-zero event is
// seen while idle, it:
//   1. records the faulting PC (pcOut - 4) in EPC and the event cause,
//   2. steers the address mux to the matching exception vector
//      (253/254/255) and pulses epcWrite,
//   3. waits MEM_WAIT cycles for the memory read to settle,
//   4. pulses pcLoad with the handler address byte taken from memData.
// While idle the mux select is 3'b000 (PC), so normal fetch proceeds.
//
// Configuration macro:
//   EXC_DIVZERO_EN  defined   : divZeroErr is recognised (select 101, cause 11)
//                   undefined : divZeroErr is ignored entirely
//
// Parameters:
//   MEM_WAIT  cycles between address presentation and valid memData (1..15)
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   opcodeErr    in   1   invalid-opcode event (sampled only when idle)
//   overflowErr  in   1   ALU overflow event (sampled only when idle)
//   divZeroErr   in   1   divide-by-zero event (sampled only when idle)
//   pcOut        in   32  current PC, already past the faulting instruction
//   memData      in   32  memory read data
//   iordmux      out  3   address select: 000 PC, 011/100/101 vectors
//   epcOut       out  32  saved exception PC
//   epcWrite     out  1   one-cycle EPC load strobe
//   pcIn         out  32  new PC value (zero outside LOAD)
//   pcLoad       out  1   one-cycle PC load strobe
//   busy         out  1   high while a sequence is running
//   cause        out  2   last cause: 00 none, 01 opcode, 10 overflow, 11 div
// -----------------------------------------------------------------------------
module exception_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opcodeErr,
    input  logic        overflowErr,
    input  logic        divZeroErr,
    input  logic [31:0] pcOut,
    input  logic [31:0] memData,
    output logic [2:0]  iordmux,
    output logic [31:0] epcOut,
    output logic        epcWrite,
    output logic [31:0] pcIn,
    output logic        pcLoad,
    output logic        busy,
    output logic [1:0]  cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAVE = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OPC  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_DIV  = 2'b11;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    // Fixed-priority encoder: opcode beats overflow beats div-zero; lower
    // priority events on the same edge are simply dropped.
    function automatic logic [1:0] pick_cause(input logic opc,
                                              input logic ovf,
                                              input logic dvz);
        logic [1:0] c;
        c = CAUSE_NONE;
        if (opc)      c = CAUSE_OPC;
        else if (ovf) c = CAUSE_OVF;
        else if (dvz) c = CAUSE_DIV;
        return c;
    endfunction

    // Mux select code for each exception vector address (253/254/255).
    function automatic logic [2:0] vector_code(input logic [1:0] c);
        logic [2:0] v;
        case (c)
            CAUSE_OPC: v = 3'b011;
            CAUSE_OVF: v = 3'b100;
            CAUSE_DIV: v = 3'b101;
            default:   v = 3'b000;
        endcase
        return v;
    endfunction

    // pcOut already points past the faulting instruction; step back one
    // word. Wraps modulo 2^32 (PC 0 yields 32'hFFFF_FFFC).
    function automatic logic [31:0] fault_pc(input logic [31:0] pc);
        return pc - 32'd4;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [1:0]  cause_q;
    logic [31:0] epc_q;
    logic        dz_evt;
    logic [1:0]  evt_cause;
    logic        take;

`ifdef EXC_DIVZERO_EN
    assign dz_evt = divZeroErr;
`else
    // Div-zero is not part of this build; the input is deliberately dropped.
    logic unused_divzero;
    assign unused_divzero = divZeroErr;
    assign dz_evt         = 1'b0;
`endif

    // Only the handler address byte is used from the memory word.
    logic unused_mem_hi;
    assign unused_mem_hi = &{1'b0, memData[31:8]};

    assign evt_cause = pick_cause(opcodeErr, overflowErr, dz_evt);

    // Next-state logic. Events are looked at only in IDLE; anything that
    // arrives while a sequence runs is ignored, not queued.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        case (state)
            S_IDLE: begin
                if (evt_cause != CAUSE_NONE) begin
                    take      = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = S_SAVE;
                end
            end
            S_SAVE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Counter was loaded with MEM_WAIT, so WAIT lasts exactly
                // MEM_WAIT cycles. The <= guards against a stray zero.
                if (cnt <= 4'd1) begin
                    state_nxt = S_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_LOAD: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            cause_q <= CAUSE_NONE;
            epc_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                cause_q <= evt_cause;
                epc_q   <= fault_pc(pcOut);
            end
        end
    end

    // Outputs are decodes of registered state only, except pcIn which
    // passes memData through during LOAD.
    always_comb begin
        iordmux  = 3'b000;
        epcWrite = 1'b0;
        pcLoad   = 1'b0;
        pcIn     = 32'd0;
        busy     = (state != S_IDLE);
        case (state)
            S_SAVE: begin
                iordmux  = vector_code(cause_q);
                epcWrite = 1'b1;
            end
            S_WAIT: begin
                iordmux = vector_code(cause_q);
            end
            S_LOAD: begin
                iordmux = vector_code(cause_q);
                pcLoad  = 1'b1;
                pcIn    = {24'd0, memData[7:0]};
            end
            default: begin
                iordmux = 3'b000;
            end
        endcase
    end

    assign epcOut = epc_q;
    assign cause  = cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

    localparam int unsigned MW = 2;

    logic        clk;
    logic        rst_n;
    logic        opcodeErr;
    logic        overflowErr;
    logic        divZeroErr;
    logic [31:0] pcOut;
    logic [31:0] memData;
    logic [2:0]  iordmux;
    logic [31:0] epcOut;
    logic        epcWrite;
    logic [31:0] pcIn;
    logic        pcLoad;
    logic        busy;
    logic [1:0]  cause;

    exception_ctrl #(.MEM_WAIT(MW)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .opcodeErr   (opcodeErr),
        .overflowErr (overflowErr),
        .divZeroErr  (divZeroErr),
        .pcOut       (pcOut),
        .memData     (memData),
        .iordmux     (iordmux),
        .epcOut      (epcOut),
        .epcWrite    (epcWrite),
        .pcIn        (pcIn),
        .pcLoad      (pcLoad),
        .busy        (busy),
        .cause       (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] epc;
        logic        ew;
        logic [31:0] pci;
        logic        pl;
        logic        b;
        logic [1:0]  cs;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } item_t;

    item_t q[$];
    int    errors = 0;
    int    checks = 0;

    logic [31:0] cur_epc;
    logic [1:0]  cur_cause;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t  act;
            it  = q.pop_front();
            act = '{sel: iordmux, epc: epcOut, ew: epcWrite, pci: pcIn,
                    pl: pcLoad, b: busy, cs: cause};
            checks++;
            if (act !== it.e) begin
                errors++;
                $display("FAIL %s: got sel=%b epc=%h ew=%b pcIn=%h pl=%b busy=%b cause=%b ; need sel=%b epc=%h ew=%b pcIn=%h pl=%b busy=%b cause=%b",
                         it.name, act.sel, act.epc, act.ew, act.pci, act.pl, act.b, act.cs,
                         it.e.sel, it.e.epc, it.e.ew, it.e.pci, it.e.pl, it.e.b, it.e.cs);
            end
        end
    end

    // Drive inputs for one cycle (just after the rising edge) and push the
    // outputs expected during that cycle.
    task automatic step(input string nm,
                        input logic o, input logic v, input logic d,
                        input logic [31:0] pc, input logic [31:0] md,
                        input logic [2:0] sel, input logic ew, input logic pl,
                        input logic b, input logic [31:0] pci);
        item_t it;
        @(posedge clk);
        #1;
        opcodeErr   = o;
        overflowErr = v;
        divZeroErr  = d;
        pcOut       = pc;
        memData     = md;
        it.name = nm;
        it.e = '{sel: sel, epc: cur_epc, ew: ew, pci: pci, pl: pl, b: b, cs: cur_cause};
        q.push_back(it);
    endtask

    task automatic idle_step(input string nm, input logic [31:0] md);
        step(nm, 1'b0, 1'b0, 1'b0, 32'h0000_1000, md, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Full sequence with hand-computed epc, select code, cause and pcIn.
    // ovf_in_wait holds overflowErr high through WAIT and LOAD.
    task automatic run_seq(input string nm,
                           input logic o, input logic v, input logic d,
                           input logic [31:0] pc, input logic [31:0] md,
                           input logic [2:0] code, input logic [1:0] cs,
                           input logic [31:0] epc, input logic [31:0] pci,
                           input logic ovf_in_wait);
        step({nm, "_evt"}, o, v, d, pc, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
        cur_cause = cs;
        cur_epc   = epc;
        step({nm, "_save"}, 1'b0, 1'b0, 1'b0, pc, 32'd0, code, 1'b1, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < MW; i++)
            step({nm, "_wait"}, 1'b0, ovf_in_wait, 1'b0, pc, md, code, 1'b0, 1'b0, 1'b1, 32'd0);
        step({nm, "_load"}, 1'b0, ovf_in_wait, 1'b0, pc, md, code, 1'b0, 1'b1, 1'b1, pci);
        idle_step({nm, "_idle1"}, md);
        idle_step({nm, "_idle2"}, md);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        opcodeErr   = 1'b0;
        overflowErr = 1'b0;
        divZeroErr  = 1'b0;
        pcOut       = 32'd0;
        memData     = 32'd0;
        cur_epc     = 32'd0;
        cur_cause   = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state held while idle; pcIn stays 0 even with memData busy.
        for (int i = 0; i < 5; i++) idle_step("reset_idle", 32'hDEAD_BEEF);

        // Overflow: epc 0x40-4=0x3C, vector 100, handler byte 0x2A.
        run_seq("ovf", 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FF2A,
                3'b100, 2'b10, 32'h0000_003C, 32'h0000_002A, 1'b0);

        // All three at once: opcode wins; epc 0x100-4=0xFC, handler 0x78.
        run_seq("prio", 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678,
                3'b011, 2'b01, 32'h0000_00FC, 32'h0000_0078, 1'b0);
        idle_step("prio_no_second", 32'd0);

        // Overflow raised during WAIT/LOAD of an opcode sequence is ignored.
        run_seq("ovf_ignored", 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_00AB,
                3'b011, 2'b01, 32'h0000_01FC, 32'h0000_00AB, 1'b1);

`ifdef EXC_DIVZERO_EN
        // Div-zero with pcOut=0: epc wraps to FFFF_FFFC.
        run_seq("divz", 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0055,
                3'b101, 2'b11, 32'hFFFF_FFFC, 32'h0000_0055, 1'b0);
`else
        // Div-zero alone never leaves IDLE in this build.
        step("divz_ignored_evt", 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0055,
             3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < MW + 3; i++)
            step("divz_ignored", 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0055,
                 3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
`endif

        // Reset in the middle of WAIT: outputs return at once, no pcLoad later.
        step("rst_evt", 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'd0,
             3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
        cur_cause = 2'b01;
        cur_epc   = 32'h0000_02FC;
        step("rst_save", 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'd0,
             3'b011, 1'b1, 1'b0, 1'b1, 32'd0);
        step("rst_wait", 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0077,
             3'b011, 1'b0, 1'b0, 1'b1, 32'd0);
        begin
            item_t it;
            @(posedge clk);
            #1 rst_n = 1'b0;
            cur_cause = 2'b00;
            cur_epc   = 32'd0;
            it.name = "rst_async";
            it.e = '{sel: 3'b000, epc: 32'd0, ew: 1'b0, pci: 32'd0,
                     pl: 1'b0, b: 1'b0, cs: 2'b00};
            q.push_back(it);
        end
        idle_step("rst_held", 32'h0000_0077);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < MW + 3; i++) idle_step("rst_no_load", 32'h0000_0077);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d records left, need 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
